lifo_stack8: RTL and testbench

- 8-entry × 4-bit LIFO stack: a pointer/control unit, a register file written at the pointer, and a read mux.
- Top of stack is presented combinationally on d_out.
- Sits between a producer that issues push/pop strobes and a consumer that reads the top entry and occupancy.
- Single clock domain.

---
 rtl/lifo_pkg.sv | 12 +
 rtl/lifo_regfile.sv | 41 ++++
 rtl/lifo_stack8.sv | 78 +++++++
 tb/tb_lifo_stack8.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_pkg.sv
// Shared sizing and types for the 8-entry x 4-bit LIFO stack.
// Pure declarations; no logic, latency or flow control of its own.
package lifo_pkg;
   localparam int WIDTH = 4;
   localparam int DEPTH = 8;
   localparam int PW    = 4;
   localparam int IW    = $clog2(DEPTH);

   typedef logic [WIDTH-1:0] data_t;
   typedef logic [PW-1:0]    ptr_t;
   typedef logic [IW-1:0]    idx_t;
endpackage

// File: rtl/lifo_regfile.sv
// DEPTH x WIDTH register file: one synchronous write port, one combinational read port.
// Write lands on the next clk rise; read has zero latency; there is no backpressure.
module lifo_regfile
   import lifo_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  we,
   input  idx_t  widx,
   input  data_t wdat,
   input  idx_t  ridx,
   output data_t rdat
);

   data_t mem_q [DEPTH];
   data_t mem_d [DEPTH];

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (we) begin
         mem_d[widx] = wdat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign rdat = mem_q[ridx];

endmodule

// File: rtl/lifo_stack8.sv
// 8-entry LIFO: pointer/flag control around a register file; top entry shown combinationally.
// One operation per clk rise; illegal requests are dropped and flagged with a one-cycle err pulse.
module lifo_stack8
   import lifo_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  push,
   input  logic  pop,
   input  data_t d_in,
   output data_t d_out,
   output ptr_t  pc,
   output logic  empty,
   output logic  full,
   output logic  err
);

   ptr_t  pc_q, pc_d;
   logic  err_q, err_d;
   logic  we;
   idx_t  widx;
   idx_t  top_idx;
   data_t top_dat;

   assign empty   = (pc_q == '0);
   assign full    = (pc_q == ptr_t'(DEPTH));
   assign top_idx = idx_t'(pc_q - 1'b1);

   always_comb begin
      pc_d  = pc_q;
      err_d = 1'b0;
      we    = 1'b0;
      widx  = idx_t'(pc_q);
      // Push+pop on an empty stack falls through to the plain push branch.
      if (push && pop && !empty) begin
         we   = 1'b1;
         widx = top_idx;
      end else if (push) begin
         if (full) begin
            err_d = 1'b1;
         end else begin
            we   = 1'b1;
            pc_d = pc_q + 1'b1;
         end
      end else if (pop) begin
         if (empty) begin
            err_d = 1'b1;
         end else begin
            pc_d = pc_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q  <= '0;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         err_q <= err_d;
      end
   end

   lifo_regfile u_regfile (
      .clk   (clk),
      .rst_n (reset),
      .we    (we),
      .widx  (widx),
      .wdat  (d_in),
      .ridx  (top_idx),
      .rdat  (top_dat)
   );

   assign d_out = empty ? '0 : top_dat;
   assign pc    = pc_q;
   assign err   = err_q;

endmodule

// File: tb/tb_lifo_stack8.sv
// Directed bench for lifo_stack8: reset, fill, overflow, drain, push+pop and async reset.
module tb_lifo_stack8;

   logic       clk = 1'b0;
   logic       reset;
   logic       push;
   logic       pop;
   logic [3:0] d_in;
   logic [3:0] d_out;
   logic [3:0] pc;
   logic       empty;
   logic       full;
   logic       err;

   int n_cmp = 0;
   int n_bad = 0;

   lifo_stack8 dut (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .d_in  (d_in),
      .d_out (d_out),
      .pc    (pc),
      .empty (empty),
      .full  (full),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; push = 1'b0; pop = 1'b0; d_in = 4'd0;
      #2;
      n_cmp++;
      if (pc !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || d_out !== 4'd0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_active: pc=%0d empty=%b full=%b d_out=%0d err=%b, want 0 1 0 0 0",
                  pc, empty, full, d_out, err);
      end
      step(); step();
      reset = 1'b1;
      step();
      n_cmp++;
      if (pc !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || d_out !== 4'd0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release: pc=%0d empty=%b full=%b d_out=%0d err=%b, want 0 1 0 0 0",
                  pc, empty, full, d_out, err);
      end
   endtask

   task automatic test_fill();
      push = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         d_in = 4'(i);
         step();
         n_cmp++;
         if (d_out !== 4'(i) || pc !== 4'(i) || err !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_%0d: d_out=%0d pc=%0d err=%b, want %0d %0d 0", i, d_out, pc, err, i, i);
         end
      end
      push = 1'b0;
      n_cmp++;
      if (full !== 1'b1 || empty !== 1'b0) begin
         n_bad++;
         $display("FAIL fill_flags: full=%b empty=%b, want 1 0", full, empty);
      end
   endtask

   task automatic test_overflow();
      push = 1'b1; d_in = 4'd9;
      step();
      push = 1'b0;
      n_cmp++;
      if (pc !== 4'd8 || d_out !== 4'd8 || err !== 1'b1 || full !== 1'b1) begin
         n_bad++;
         $display("FAIL overflow: pc=%0d d_out=%0d err=%b full=%b, want 8 8 1 1", pc, d_out, err, full);
      end
      step();
      n_cmp++;
      if (err !== 1'b0 || pc !== 4'd8) begin
         n_bad++;
         $display("FAIL overflow_err_clear: err=%b pc=%0d, want 0 8", err, pc);
      end
      // Replace-top is legal while full and must not flag an error.
      push = 1'b1; pop = 1'b1; d_in = 4'd8;
      step();
      push = 1'b0; pop = 1'b0;
      n_cmp++;
      if (pc !== 4'd8 || d_out !== 4'd8 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL replace_full: pc=%0d d_out=%0d err=%b, want 8 8 0", pc, d_out, err);
      end
   endtask

   task automatic test_drain();
      pop = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         step();
         n_cmp++;
         if (d_out !== 4'(i) || pc !== 4'(i) || err !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_%0d: d_out=%0d pc=%0d err=%b, want %0d %0d 0", i, d_out, pc, err, i, i);
         end
      end
      n_cmp++;
      if (empty !== 1'b1 || full !== 1'b0) begin
         n_bad++;
         $display("FAIL drain_flags: empty=%b full=%b, want 1 0", empty, full);
      end
      step();
      pop = 1'b0;
      n_cmp++;
      if (err !== 1'b1 || pc !== 4'd0 || d_out !== 4'd0) begin
         n_bad++;
         $display("FAIL underflow: err=%b pc=%0d d_out=%0d, want 1 0 0", err, pc, d_out);
      end
      step();
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++;
         $display("FAIL underflow_err_clear: err=%b, want 0", err);
      end
   endtask

   task automatic test_simultaneous();
      // Push+pop on an empty stack acts as a plain push.
      push = 1'b1; pop = 1'b1; d_in = 4'd3;
      step();
      pop = 1'b0; d_in = 4'd5;
      n_cmp++;
      if (pc !== 4'd1 || d_out !== 4'd3 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL pushpop_empty: pc=%0d d_out=%0d err=%b, want 1 3 0", pc, d_out, err);
      end
      step();
      n_cmp++;
      if (pc !== 4'd2 || d_out !== 4'd5) begin
         n_bad++;
         $display("FAIL simul_setup: pc=%0d d_out=%0d, want 2 5", pc, d_out);
      end
      pop = 1'b1; d_in = 4'd6;
      step();
      n_cmp++;
      if (pc !== 4'd2 || d_out !== 4'd6 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL replace_top: pc=%0d d_out=%0d err=%b, want 2 6 0", pc, d_out, err);
      end
      push = 1'b0;
      step();
      pop = 1'b0;
      n_cmp++;
      if (pc !== 4'd1 || d_out !== 4'd3) begin
         n_bad++;
         $display("FAIL pop_after_replace: pc=%0d d_out=%0d, want 1 3", pc, d_out);
      end
   endtask

   task automatic test_async_reset();
      push = 1'b1;
      for (int i = 2; i <= 4; i++) begin
         d_in = 4'(i + 8);
         step();
      end
      n_cmp++;
      if (pc !== 4'd4 || d_out !== 4'd12) begin
         n_bad++;
         $display("FAIL async_setup: pc=%0d d_out=%0d, want 4 12", pc, d_out);
      end
      #2;
      reset = 1'b0;
      #1;
      n_cmp++;
      if (pc !== 4'd0 || d_out !== 4'd0 || empty !== 1'b1 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset: pc=%0d d_out=%0d empty=%b err=%b, want 0 0 1 0", pc, d_out, empty, err);
      end
      step();
      n_cmp++;
      if (pc !== 4'd0) begin
         n_bad++;
         $display("FAIL async_hold: pc=%0d, want 0 while push held in reset", pc);
      end
      reset = 1'b1; push = 1'b1; d_in = 4'd7;
      step();
      push = 1'b0;
      n_cmp++;
      if (pc !== 4'd1 || d_out !== 4'd7 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL post_reset_push: pc=%0d d_out=%0d err=%b, want 1 7 0", pc, d_out, err);
      end
      // Entries cleared by reset: a pop exposes nothing stale.
      pop = 1'b1;
      step();
      pop = 1'b0;
      n_cmp++;
      if (pc !== 4'd0 || d_out !== 4'd0 || empty !== 1'b1) begin
         n_bad++;
         $display("FAIL post_reset_pop: pc=%0d d_out=%0d empty=%b, want 0 0 1", pc, d_out, empty);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_drain();
      test_simultaneous();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
